traffic_light_safety_monitor: RTL
=================================

TRAFFIC_LIGHT_SAFETY_MONITOR -- requirements
Module: traffic_light_safety_monitor

Interface
REQ-001 Parameter FLASH_HALF, default 4: cycles per on-phase and per off-phase of fault flashing; legal range 1..255.
REQ-002 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port light_NS, input, 2: NS command from the light controller; 00 red, 10 green, 01 yellow, 11 illegal.
REQ-005 Port light_EW, input, 2: EW command, same encoding as light_NS.
REQ-006 Port fault_clear, input, 1: operator request to leave FAULT; level-sampled each cycle.
REQ-007 Port lamp_NS, output, 3: one-hot NS lamp drive {R,Y,G}; 100 red, 010 yellow, 001 green, 000 dark.
REQ-008 Port lamp_EW, output, 3: one-hot EW lamp drive, same encoding as lamp_NS.
REQ-009 Port fault, output, 1: high while in FAULT.
REQ-010 Port fault_code, output, 2: cause of the most recent FAULT entry; 00 none, 01 illegal encoding, 10 conflict, 11 bad transition.
REQ-011 Port fault_count, output, 8: number of FAULT entries since reset; saturates at 255.

Function
REQ-012 States: MONITOR and FAULT; the block SHALL leave reset in MONITOR.
REQ-013 prev_NS/prev_EW registers SHALL hold the inputs sampled on the previous edge; they are 00 after reset and update every cycle in both states.
REQ-014 Illegal encoding: either input equals 11.
REQ-015 Conflict: light_NS != 00 and light_EW != 00 in the same cycle.
REQ-016 Bad transition, per direction, prev->current: only 00->00, 00->10, 10->10, 10->01, 01->01 and 01->00 are legal; 10->00, 00->01 and 01->10 are bad.
REQ-017 Violation priority: illegal encoding > conflict > bad transition; fault_code SHALL take the code of the highest-priority violation present.
REQ-018 In MONITOR with no violation, lamp_NS/lamp_EW SHALL equal the one-hot decode of the inputs sampled at the same edge, giving one cycle latency.
REQ-019 In MONITOR, a violation sampled at an edge SHALL move the block to FAULT at that edge: fault=1, fault_code updated, fault_count+1 (saturating), both lamps 100.
REQ-020 In FAULT, further violations SHALL NOT change fault_code or fault_count.
REQ-021 Exit: in FAULT, if fault_clear=1 and light_NS=light_EW=00 at an edge, the block SHALL enter MONITOR with fault=0 and both lamps 100; fault_code and fault_count SHALL be retained.
REQ-022 If fault_clear=1 while either input is non-00, the block SHALL remain in FAULT.
REQ-023 Exit transition check: the first MONITOR cycle SHALL check transitions against prev=00/00.
REQ-024 fault_count at 255 SHALL remain 255 on further FAULT entries.

Reset
REQ-025 While reset=1 (asynchronous): state=MONITOR, lamp_NS=lamp_EW=100, fault=0, fault_code=00, fault_count=0, prev_NS=prev_EW=00, flash counter=0.
REQ-026 Reset asserted during FAULT SHALL clear all state immediately, without waiting for a clock edge.

Configuration
REQ-027 Macro TLSM_FLASH_EN defined: in FAULT, both lamps SHALL show 100 for FLASH_HALF cycles, then 000 for FLASH_HALF cycles, repeating; phase counting starts at FAULT entry with the on-phase.
REQ-028 Macro TLSM_FLASH_EN undefined: in FAULT, both lamps SHALL hold steady 100, and no flash counter SHALL be instantiated.

Verification
REQ-029 Normal cycle: reset, then inputs 00/00, 10/00, 01/00, 00/10, 00/01, 10/00 on consecutive edges -> lamps lag one cycle (100/100, 001/100, 010/100, 100/001, 100/010, 001/100); fault=0, fault_count=0.
REQ-030 Conflict: in MONITOR drive 10/10 -> at that edge fault=1, fault_code=10, fault_count=1, lamps 100/100.
REQ-031 Priority and bad transition:
  - drive 11/10 -> fault_code=01.
  - separately, drive 10/00 then 00/00 -> fault_code=11.
REQ-032 Clear handling: in FAULT, fault_clear=1 with inputs 10/00 -> stays in FAULT; then inputs 00/00 with fault_clear=1 -> fault=0 next edge, fault_code retained.
REQ-033 Flash (TLSM_FLASH_EN, FLASH_HALF=2): after FAULT entry, lamps 100,100,000,000,100 on consecutive cycles; without the macro, steady 100.
REQ-034 Saturation and reset: force 256 FAULT entries -> fault_count=255; assert reset mid-FAULT between edges -> all outputs at reset values immediately.

Source files
------------

// File: rtl/traffic_light_safety_monitor.sv
// Safety monitor between a traffic light controller and the lamp drivers.
// Optional fault flashing is enabled by defining TLSM_FLASH_EN.
module traffic_light_safety_monitor #(
    parameter int FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] light_NS,
    input  logic [1:0] light_EW,
    input  logic       fault_clear,
    output logic [2:0] lamp_NS,
    output logic [2:0] lamp_EW,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [7:0] fault_count
);

    typedef enum logic {MONITOR, FAULT} state_t;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_ILLEGAL = 2'b01;
    localparam logic [1:0] CODE_CONFLICT = 2'b10;
    localparam logic [1:0] CODE_BADTRANS = 2'b11;
    localparam logic [2:0] LAMP_RED     = 3'b100;
    localparam logic [2:0] LAMP_DARK    = 3'b000;

    generate
        if (FLASH_HALF < 1 || FLASH_HALF > 255) begin : g_bad_param
            $error("FLASH_HALF must be within 1..255");
        end
    endgenerate

    state_t     state;
    state_t     next_state;
    logic [1:0] prev_ns;
    logic [1:0] prev_ew;
    logic [2:0] lamp_ns_q;
    logic [2:0] lamp_ew_q;
    logic [1:0] viol_code;
    logic       flash_on;

    function automatic logic [2:0] decode_lamp(input logic [1:0] cmd);
        case (cmd)
            2'b00:   decode_lamp = 3'b100;
            2'b10:   decode_lamp = 3'b001;
            2'b01:   decode_lamp = 3'b010;
            default: decode_lamp = 3'b000;
        endcase
    endfunction

    // Only green->red, red->yellow and yellow->green skip a required phase.
    function automatic logic bad_step(input logic [1:0] prev, input logic [1:0] cur);
        bad_step = (prev == 2'b10 && cur == 2'b00) ||
                   (prev == 2'b00 && cur == 2'b01) ||
                   (prev == 2'b01 && cur == 2'b10);
    endfunction

    always_comb begin
        viol_code = CODE_NONE;
        if (light_NS == 2'b11 || light_EW == 2'b11)
            viol_code = CODE_ILLEGAL;
        else if (light_NS != 2'b00 && light_EW != 2'b00)
            viol_code = CODE_CONFLICT;
        else if (bad_step(prev_ns, light_NS) || bad_step(prev_ew, light_EW))
            viol_code = CODE_BADTRANS;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= MONITOR;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            MONITOR: if (viol_code != CODE_NONE) next_state = FAULT;
            FAULT:   if (fault_clear && light_NS == 2'b00 && light_EW == 2'b00)
                         next_state = MONITOR;
            default: next_state = MONITOR;
        endcase
    end

    always_comb begin
        fault   = (state == FAULT);
        lamp_NS = lamp_ns_q;
        lamp_EW = lamp_ew_q;
        if (state == FAULT) begin
            lamp_NS = flash_on ? LAMP_RED : LAMP_DARK;
            lamp_EW = flash_on ? LAMP_RED : LAMP_DARK;
        end
    end

    // History, lamp decode and fault bookkeeping; the decode is overridden in FAULT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_ns     <= 2'b00;
            prev_ew     <= 2'b00;
            lamp_ns_q   <= LAMP_RED;
            lamp_ew_q   <= LAMP_RED;
            fault_code  <= CODE_NONE;
            fault_count <= 8'd0;
        end else begin
            prev_ns   <= light_NS;
            prev_ew   <= light_EW;
            lamp_ns_q <= decode_lamp(light_NS);
            lamp_ew_q <= decode_lamp(light_EW);
            if (state == MONITOR && viol_code != CODE_NONE) begin
                fault_code <= viol_code;
                if (fault_count != 8'hFF)
                    fault_count <= fault_count + 8'd1;
            end
        end
    end

`ifdef TLSM_FLASH_EN
    logic [7:0] flash_cnt;
    logic       flash_off;

    // Counter restarts on every FAULT entry so each fault begins with the lit phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flash_cnt <= 8'd0;
            flash_off <= 1'b0;
        end else if (state == FAULT && next_state == FAULT) begin
            if (flash_cnt == 8'(FLASH_HALF - 1)) begin
                flash_cnt <= 8'd0;
                flash_off <= ~flash_off;
            end else begin
                flash_cnt <= flash_cnt + 8'd1;
            end
        end else begin
            flash_cnt <= 8'd0;
            flash_off <= 1'b0;
        end
    end

    assign flash_on = ~flash_off;
`else
    assign flash_on = 1'b1;
`endif

endmodule
